// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the inter-stage pipeline registers of the
// 5-stage MIPS core. Every stage boundary imports this package.
package pipe_stage_reg_pkg;

    // Architectural register address width (rs/rt/rd fields).
    localparam int REG_ADDR_W = 5;

    // Width of the program counter.
    localparam int PC_W = 32;

    // Default reset/bubble PC: the MARS-style text segment base.
    localparam logic [PC_W-1:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Default width of the Tnew forwarding field.
    localparam int TNEW_W_DEFAULT = 2;

    // A nop payload is all-zero; downstream decoders treat it as "do nothing".
    localparam logic NOP_PAYLOAD_BIT = 1'b0;

    // What the stage register does at the next edge (reset is handled
    // separately because it is sampled directly in the flop process).
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } stage_action_e;

    // Flush beats stall, stall beats load.
    function automatic stage_action_e decode_action(input logic flush, input logic en);
        if (flush) begin
            return ACT_FLUSH;
        end else if (!en) begin
            return ACT_HOLD;
        end
        return ACT_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for per-stage stall/flush performance counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; increment sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register with synchronous reset overriding clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register (F/D, D/E, E/M, M/W) with stall, flush
// bubbles, valid bit, Tnew countdown and stall/flush performance counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int              DATA_W   = 64,
    parameter int              TNEW_W   = TNEW_W_DEFAULT,
    parameter bit              TNEW_DEC = 1'b1,
    parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEFAULT,
    parameter bit              KEEP_PC  = 1'b0,
    parameter int              CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  cnt_clr,
    input  logic                  in_valid,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  in_bd,
    input  logic [REG_ADDR_W-1:0] in_a1,
    input  logic [REG_ADDR_W-1:0] in_a2,
    input  logic [REG_ADDR_W-1:0] in_wr,
    input  logic [TNEW_W-1:0]     in_tnew,
    input  logic [DATA_W-1:0]     in_payload,
    output logic                  out_valid,
    output logic [PC_W-1:0]       out_pc,
    output logic                  out_bd,
    output logic [REG_ADDR_W-1:0] out_a1,
    output logic [REG_ADDR_W-1:0] out_a2,
    output logic [REG_ADDR_W-1:0] out_wr,
    output logic [TNEW_W-1:0]     out_tnew,
    output logic [DATA_W-1:0]     out_payload,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    stage_action_e action;

    logic                  valid_q,   valid_d;
    logic [PC_W-1:0]       pc_q,      pc_d;
    logic                  bd_q,      bd_d;
    logic [REG_ADDR_W-1:0] a1_q,      a1_d;
    logic [REG_ADDR_W-1:0] a2_q,      a2_d;
    logic [REG_ADDR_W-1:0] wr_q,      wr_d;
    logic [TNEW_W-1:0]     tnew_q,    tnew_d;
    logic [DATA_W-1:0]     payload_q, payload_d;
    logic [TNEW_W-1:0]     tnew_loaded;

    assign action = decode_action(flush, en);

    // Tnew entering this stage is one cycle closer to ready, bottoming out at 0.
    always_comb begin
        tnew_loaded = in_tnew;
        if (TNEW_DEC && (in_tnew != '0)) begin
            tnew_loaded = in_tnew - TNEW_W'(1);
        end
    end

    // Next stage contents: bubble on flush, keep on stall, copy upstream on load.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        wr_d      = wr_q;
        tnew_d    = tnew_q;
        payload_d = payload_q;
        unique case (action)
            ACT_FLUSH: begin
                valid_d   = 1'b0;
                pc_d      = KEEP_PC ? in_pc : PC_RESET;
                bd_d      = KEEP_PC ? in_bd : 1'b0;
                a1_d      = '0;
                a2_d      = '0;
                wr_d      = '0;
                tnew_d    = '0;
                payload_d = {DATA_W{NOP_PAYLOAD_BIT}};
            end
            ACT_LOAD: begin
                valid_d   = in_valid;
                pc_d      = in_pc;
                bd_d      = in_bd;
                a1_d      = in_a1;
                a2_d      = in_a2;
                wr_d      = in_wr;
                tnew_d    = tnew_loaded;
                payload_d = in_payload;
            end
            default: begin
            end
        endcase
    end

    // Stage register; reset overrides any flush/stall in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= PC_RESET;
            bd_q      <= 1'b0;
            a1_q      <= '0;
            a2_q      <= '0;
            wr_q      <= '0;
            tnew_q    <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            wr_q      <= wr_d;
            tnew_q    <= tnew_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_bd      = bd_q;
    assign out_a1      = a1_q;
    assign out_a2      = a2_q;
    assign out_wr      = wr_q;
    assign out_tnew    = tnew_q;
    assign out_payload = payload_q;

    // A stall cycle is one where the stage is held and not being flushed.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (~en & ~flush),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (flush),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. Three instances share one stimulus:
//   u0: defaults (KEEP_PC=0, TNEW_DEC=1, CNT_W=16)
//   u1: KEEP_PC=1, TNEW_DEC=0
//   u2: CNT_W=4 for counter saturation
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset, en, flush, cnt_clr, in_valid, in_bd;
    logic [31:0] in_pc;
    logic [4:0]  in_a1, in_a2, in_wr;
    logic [1:0]  in_tnew;
    logic [63:0] in_payload;

    logic        d0_valid, d1_valid, d2_valid;
    logic [31:0] d0_pc, d1_pc, d2_pc;
    logic        d0_bd, d1_bd, d2_bd;
    logic [4:0]  d0_a1, d1_a1, d2_a1;
    logic [4:0]  d0_a2, d1_a2, d2_a2;
    logic [4:0]  d0_wr, d1_wr, d2_wr;
    logic [1:0]  d0_tnew, d1_tnew, d2_tnew;
    logic [63:0] d0_pay, d1_pay, d2_pay;
    logic [15:0] d0_stall, d0_flush, d1_stall, d1_flush;
    logic [3:0]  d2_stall, d2_flush;

    int total = 0;
    int bad   = 0;

    // Behavioural state of one stage boundary, as the rules describe it.
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  a1, a2, wr;
        int          tnew;
        logic [63:0] pay;
        int          stall, flushc;
    } model_t;

    model_t m [3];

    // One directed vector: inputs, expected u0 outputs, expected u1 pc/bd.
    typedef struct {
        logic        rst, en, fl, clr, valid;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  wr;
        logic [1:0]  tnew;
        logic [63:0] pay;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_bd;
        logic [4:0]  e_wr;
        logic [1:0]  e_tnew;
        logic [63:0] e_pay;
        int          e_stall, e_flush;
        logic [31:0] k_pc;
        logic        k_bd;
    } vec_t;

    vec_t vecs [14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg u0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_a1(in_a1), .in_a2(in_a2),
        .in_wr(in_wr), .in_tnew(in_tnew), .in_payload(in_payload),
        .out_valid(d0_valid), .out_pc(d0_pc), .out_bd(d0_bd), .out_a1(d0_a1), .out_a2(d0_a2),
        .out_wr(d0_wr), .out_tnew(d0_tnew), .out_payload(d0_pay),
        .stall_cnt(d0_stall), .flush_cnt(d0_flush)
    );

    pipe_stage_reg #(.KEEP_PC(1'b1), .TNEW_DEC(1'b0)) u1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_a1(in_a1), .in_a2(in_a2),
        .in_wr(in_wr), .in_tnew(in_tnew), .in_payload(in_payload),
        .out_valid(d1_valid), .out_pc(d1_pc), .out_bd(d1_bd), .out_a1(d1_a1), .out_a2(d1_a2),
        .out_wr(d1_wr), .out_tnew(d1_tnew), .out_payload(d1_pay),
        .stall_cnt(d1_stall), .flush_cnt(d1_flush)
    );

    pipe_stage_reg #(.CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_a1(in_a1), .in_a2(in_a2),
        .in_wr(in_wr), .in_tnew(in_tnew), .in_payload(in_payload),
        .out_valid(d2_valid), .out_pc(d2_pc), .out_bd(d2_bd), .out_a1(d2_a1), .out_a2(d2_a2),
        .out_wr(d2_wr), .out_tnew(d2_tnew), .out_payload(d2_pay),
        .stall_cnt(d2_stall), .flush_cnt(d2_flush)
    );

    // Single comparison with failure report.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Advance one boundary's model by one edge using the current inputs.
    task automatic modelStep(input int idx, input bit keep, input bit dec, input int cmax);
        if (reset) begin
            m[idx].valid = 1'b0; m[idx].pc = 32'h3000; m[idx].bd = 1'b0;
            m[idx].a1 = 0; m[idx].a2 = 0; m[idx].wr = 0; m[idx].tnew = 0; m[idx].pay = 0;
            m[idx].stall = 0; m[idx].flushc = 0;
        end else begin
            if (cnt_clr) begin
                m[idx].stall = 0;
                m[idx].flushc = 0;
            end else begin
                if (!en && !flush && m[idx].stall < cmax) m[idx].stall++;
                if (flush && m[idx].flushc < cmax) m[idx].flushc++;
            end
            if (flush) begin
                m[idx].valid = 1'b0;
                m[idx].pc = keep ? in_pc : 32'h3000;
                m[idx].bd = keep ? in_bd : 1'b0;
                m[idx].a1 = 0; m[idx].a2 = 0; m[idx].wr = 0; m[idx].tnew = 0; m[idx].pay = 0;
            end else if (en) begin
                m[idx].valid = in_valid; m[idx].pc = in_pc; m[idx].bd = in_bd;
                m[idx].a1 = in_a1; m[idx].a2 = in_a2; m[idx].wr = in_wr; m[idx].pay = in_payload;
                if (dec) m[idx].tnew = (in_tnew == 0) ? 0 : int'(in_tnew) - 1;
                else     m[idx].tnew = int'(in_tnew);
            end
        end
    endtask

    // Compare every output of one instance against its model.
    task automatic checkInstance(input int idx);
        logic        av, abd;
        logic [31:0] apc;
        logic [4:0]  aa1, aa2, awr;
        logic [1:0]  at;
        logic [63:0] ap;
        logic [15:0] ast, afl;
        case (idx)
            0: begin av = d0_valid; apc = d0_pc; abd = d0_bd; aa1 = d0_a1; aa2 = d0_a2; awr = d0_wr;
                     at = d0_tnew; ap = d0_pay; ast = d0_stall; afl = d0_flush; end
            1: begin av = d1_valid; apc = d1_pc; abd = d1_bd; aa1 = d1_a1; aa2 = d1_a2; awr = d1_wr;
                     at = d1_tnew; ap = d1_pay; ast = d1_stall; afl = d1_flush; end
            default: begin av = d2_valid; apc = d2_pc; abd = d2_bd; aa1 = d2_a1; aa2 = d2_a2; awr = d2_wr;
                     at = d2_tnew; ap = d2_pay; ast = {12'd0, d2_stall}; afl = {12'd0, d2_flush}; end
        endcase
        checkOutput($sformatf("u%0d valid", idx), 64'(av),  64'(m[idx].valid));
        checkOutput($sformatf("u%0d pc", idx),    64'(apc), 64'(m[idx].pc));
        checkOutput($sformatf("u%0d bd", idx),    64'(abd), 64'(m[idx].bd));
        checkOutput($sformatf("u%0d a1", idx),    64'(aa1), 64'(m[idx].a1));
        checkOutput($sformatf("u%0d a2", idx),    64'(aa2), 64'(m[idx].a2));
        checkOutput($sformatf("u%0d wr", idx),    64'(awr), 64'(m[idx].wr));
        checkOutput($sformatf("u%0d tnew", idx),  64'(at),  64'(m[idx].tnew));
        checkOutput($sformatf("u%0d payload", idx), ap,     m[idx].pay);
        checkOutput($sformatf("u%0d stall_cnt", idx), 64'(ast), 64'(m[idx].stall));
        checkOutput($sformatf("u%0d flush_cnt", idx), 64'(afl), 64'(m[idx].flushc));
    endtask

    // Drive one cycle of inputs, clock it, update models and check all instances.
    task automatic applyStimulus(input logic r, input logic e, input logic f, input logic c,
                                 input logic v, input logic [31:0] pc, input logic bd,
                                 input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wr,
                                 input logic [1:0] tn, input logic [63:0] pay);
        reset = r; en = e; flush = f; cnt_clr = c; in_valid = v; in_pc = pc; in_bd = bd;
        in_a1 = a1; in_a2 = a2; in_wr = wr; in_tnew = tn; in_payload = pay;
        @(posedge clk);
        modelStep(0, 1'b0, 1'b1, 65535);
        modelStep(1, 1'b1, 1'b0, 65535);
        modelStep(2, 1'b0, 1'b1, 15);
        #1;
        checkInstance(0);
        checkInstance(1);
        checkInstance(2);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; in_bd = 1'b0;
        in_pc = '0; in_a1 = '0; in_a2 = '0; in_wr = '0; in_tnew = '0; in_payload = '0;

        //          rst  en   fl   clr  vld  pc            bd   wr  tn  pay       | e_vld e_pc bd wr tn pay     stall flush | k_pc k_bd
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h0000_3abc,1'b1,5'd5, 2'd3,64'hff,   1'b0,32'h3000,1'b0,5'd0, 2'd0,64'h0,    0,0, 32'h3000,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h0000_3abc,1'b1,5'd5, 2'd3,64'hff,   1'b0,32'h3000,1'b0,5'd0, 2'd0,64'h0,    0,0, 32'h3000,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h0000_3004,1'b0,5'd8, 2'd2,64'hdead, 1'b1,32'h3004,1'b0,5'd8, 2'd1,64'hdead, 0,0, 32'h3004,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h0000_3008,1'b0,5'd9, 2'd0,64'hbeef, 1'b1,32'h3008,1'b0,5'd9, 2'd0,64'hbeef, 0,0, 32'h3008,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h0000_3010,1'b0,5'd10,2'd3,64'h1234, 1'b1,32'h3010,1'b0,5'd10,2'd2,64'h1234, 0,0, 32'h3010,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_3014,1'b0,5'd11,2'd1,64'h5555, 1'b1,32'h3010,1'b0,5'd10,2'd2,64'h1234, 1,0, 32'h3010,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_3014,1'b0,5'd11,2'd1,64'h5555, 1'b1,32'h3010,1'b0,5'd10,2'd2,64'h1234, 2,0, 32'h3010,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_3014,1'b0,5'd11,2'd1,64'h5555, 1'b1,32'h3010,1'b0,5'd10,2'd2,64'h1234, 3,0, 32'h3010,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,32'h0000_3020,1'b1,5'd12,2'd2,64'h6666, 1'b0,32'h3000,1'b0,5'd0, 2'd0,64'h0,    3,1, 32'h3020,1'b1};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_3024,1'b1,5'd3, 2'd1,64'h77,   1'b0,32'h3024,1'b1,5'd3, 2'd0,64'h77,   3,1, 32'h3024,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_3028,1'b0,5'd7, 2'd2,64'h88,   1'b0,32'h3024,1'b1,5'd3, 2'd0,64'h77,   0,0, 32'h3024,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_3028,1'b0,5'd7, 2'd2,64'h88,   1'b0,32'h3024,1'b1,5'd3, 2'd0,64'h77,   1,0, 32'h3024,1'b1};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b0,1'b1,32'h0000_3040,1'b1,5'd6, 2'd3,64'h99,   1'b0,32'h3000,1'b0,5'd0, 2'd0,64'h0,    0,0, 32'h3000,1'b0};
        vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h0000_3044,1'b0,5'd4, 2'd1,64'h99,   1'b1,32'h3044,1'b0,5'd4, 2'd0,64'h99,   0,0, 32'h3044,1'b0};

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].fl, vecs[i].clr, vecs[i].valid,
                          vecs[i].pc, vecs[i].bd, 5'(i), 5'(i + 1), vecs[i].wr, vecs[i].tnew, vecs[i].pay);
            checkOutput($sformatf("vec%0d valid", i), 64'(d0_valid), 64'(vecs[i].e_valid));
            checkOutput($sformatf("vec%0d pc", i),    64'(d0_pc),    64'(vecs[i].e_pc));
            checkOutput($sformatf("vec%0d bd", i),    64'(d0_bd),    64'(vecs[i].e_bd));
            checkOutput($sformatf("vec%0d wr", i),    64'(d0_wr),    64'(vecs[i].e_wr));
            checkOutput($sformatf("vec%0d tnew", i),  64'(d0_tnew),  64'(vecs[i].e_tnew));
            checkOutput($sformatf("vec%0d payload", i), d0_pay,      vecs[i].e_pay);
            checkOutput($sformatf("vec%0d stall_cnt", i), 64'(d0_stall), 64'(vecs[i].e_stall));
            checkOutput($sformatf("vec%0d flush_cnt", i), 64'(d0_flush), 64'(vecs[i].e_flush));
            checkOutput($sformatf("vec%0d keep pc", i), 64'(d1_pc), 64'(vecs[i].k_pc));
            checkOutput($sformatf("vec%0d keep bd", i), 64'(d1_bd), 64'(vecs[i].k_bd));
        end

        $display("[TB] counter saturation and clear");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3050, 1'b0, 5'd1, 5'd2, 5'd3, 2'd1, 64'h1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3054, 1'b0, 5'd1, 5'd2, 5'd3, 2'd1, 64'h2);
        end
        checkOutput("small stall_cnt saturated", 64'(d2_stall), 64'd15);
        checkOutput("wide stall_cnt after 20", 64'(d0_stall), 64'd20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3058, 1'b0, 5'd1, 5'd2, 5'd3, 2'd1, 64'h3);
        checkOutput("small stall_cnt cleared", 64'(d2_stall), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h305c, 1'b0, 5'd1, 5'd2, 5'd3, 2'd1, 64'h4);
        checkOutput("small stall_cnt after clear", 64'(d2_stall), 64'd1);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3060, 1'b1, 5'd1, 5'd2, 5'd3, 2'd2, 64'h5);
        end
        checkOutput("small flush_cnt saturated", 64'(d2_flush), 64'd15);
        checkOutput("small stall_cnt held by flush", 64'(d2_stall), 64'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(31) == 0), ($urandom_range(3) != 0),
                          ($urandom_range(7) == 0), ($urandom_range(15) == 0),
                          1'($urandom), $urandom, 1'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 2'($urandom), {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core; one instance per boundary (F/D, D/E, E/M, M/W).
- Generalises the fixed D→E register with:
  - stall/hold, independent of flush;
  - configurable bubble PC policy for later EPC support;
  - valid bit;
  - saturating Tnew countdown of configurable width;
  - per-stage saturating stall and flush counters for performance debug.

Parameters:
- DATA_W, 64, width of opaque control/data payload (ALU op, MemToReg, extended imm, RD1/RD2 packed by caller).
- TNEW_W, 2, width of Tnew field.
- TNEW_DEC, 1, 1 = decrement Tnew on load (saturating at 0); 0 = pass through unchanged.
- PC_RESET, 32'h0000_3000, PC value after reset and on bubbles when KEEP_PC=0.
- KEEP_PC, 0, 1 = a flush bubble takes in_pc and in_bd; 0 = the bubble takes PC_RESET and bd=0.
- CNT_W, 16, width of stall/flush performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  1 = load next stage contents; 0 = hold (stall)
- flush  in  1  insert bubble at next edge
- cnt_clr  in  1  synchronous clear of both counters
- in_valid  in  1  upstream slot holds a real instruction
- in_pc  in  32  upstream PC
- in_bd  in  1  upstream is in a branch delay slot
- in_a1  in  5  rs read address
- in_a2  in  5  rt read address
- in_wr  in  5  destination register, 0 = none
- in_tnew  in  TNEW_W  cycles until result is available, relative to upstream stage
- in_payload  in  DATA_W  opaque bundle
- out_valid  out  1
- out_pc  out  32
- out_bd  out  1
- out_a1  out  5
- out_a2  out  5
- out_wr  out  5
- out_tnew  out  TNEW_W
- out_payload  out  DATA_W
- stall_cnt  out  CNT_W  cycles with en=0 and flush=0
- flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- All outputs are registered; latency is 1 cycle from in_* to out_*. There are no combinational paths.
- Priority at each rising edge: reset > flush > (en=0 hold) > load.
- reset:
  - out_valid=0, out_pc=PC_RESET, out_bd=0;
  - out_a1, out_a2, out_wr, out_tnew, out_payload = 0;
  - stall_cnt=0, flush_cnt=0.
- flush (regardless of en), produces a bubble:
  - out_valid=0, out_wr=0, out_a1=0, out_a2=0, out_tnew=0, out_payload=0;
  - out_pc/out_bd = in_pc/in_bd if KEEP_PC=1, else PC_RESET/0.
  - A bubble must never write the register file or memory: downstream decodes payload==0 as nop.
- Hold (en=0, flush=0): all data outputs keep their previous values. out_tnew is not decremented while held.
- Load (en=1, flush=0): every out_* takes the corresponding in_*, except:
  - out_tnew = in_tnew-1 if TNEW_DEC=1 and in_tnew!=0;
  - out_tnew = 0 if TNEW_DEC=1 and in_tnew==0;
  - out_tnew = in_tnew if TNEW_DEC=0.
- in_valid=0 on load still copies all fields; consumers must qualify with out_valid.
- Counters:
  - Each increments by 1 in its qualifying cycle and saturates at all-ones (no wrap).
  - cnt_clr zeroes both counters and takes precedence over increment in the same cycle.
  - Counters still update during hold/flush; reset overrides cnt_clr.
  - In a cycle with flush=1 and en=0, only flush_cnt increments.
- Reset asserted mid-stall or mid-flush: the reset state is taken at that edge, and stall/flush are ignored.
- Deassert reset with en=1: the first load occurs at the next edge.

Decomposition:
- Shared package (constants header):
  - PC_RESET default value 32'h0000_3000;
  - TNEW_W default;
  - nop payload encoding (all-zero);
  - register address width 5.
- One natural sub-module: sat_counter (parameter W; ports clk, reset, clr, inc, q). It is instantiated twice, for stall_cnt and flush_cnt.
- Payload packing/unpacking stays in the instantiating stage, not in this block.

Test Plan:
- Reset: hold reset 2 cycles with in_* nonzero → out_pc=0x3000, out_valid=0, all other outputs 0, both counters 0.
- Load with Tnew decrement (TNEW_DEC=1): in_pc=0x3004, in_wr=8, in_tnew=2, in_payload=0xDEAD, en=1 → next cycle out_tnew=1, out_wr=8, out_payload=0xDEAD. Then in_tnew=0 → out_tnew=0 (saturating, no wrap to 3).
- Stall: load pc=0x3010, then en=0 for 3 cycles while in_pc changes to 0x3014 → out_pc stays 0x3010 throughout, out_tnew unchanged, stall_cnt=3.
- Flush under stall:
  - en=0, flush=1, in_pc=0x3020, in_bd=1;
  - KEEP_PC=0 → out_pc=0x3000, out_bd=0, out_valid=0, out_wr=0;
  - KEEP_PC=1 → out_pc=0x3020, out_bd=1;
  - in both cases flush_cnt=1 and stall_cnt unchanged.
- Counter saturation and clear:
  - CNT_W=4, en=0 for 20 cycles → stall_cnt=15.
  - Pulse cnt_clr with en=0 → stall_cnt=0 that cycle, 1 the cycle after.
- Reset mid-operation: flush=1 and reset=1 on the same edge with KEEP_PC=1 and in_pc=0x3040 → out_pc=0x3000 (reset wins), flush_cnt=0.
